btb_assoc: RTL

//  Parametrised set-associative branch target buffer with tags, valid bits and per-entry 2-bit

---
 rtl/btb_if.sv | 25 ++
 rtl/btb_assoc.sv | 132 +++++++++++++
 2 files changed

// File: rtl/btb_if.sv
// Fetch-side lookup and MEM-side training bus of the branch target buffer.
// Update handshake: upd_valid is a one-cycle strobe with no backpressure; it only takes effect while ready is high.
interface btb_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ready;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;

    modport master (
        output pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  hit, pred_taken, pred_target, ready
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_taken, upd_target,
        output hit, pred_taken, pred_target, ready
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: same-cycle lookup for fetch, training from MEM,
// and a one-set-per-cycle invalidation sweep after reset or flush.
module btb_assoc #(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 2,
    parameter int TAG_W    = 8,
    parameter int ADDR_W   = 32
) (
    input  logic    clk,
    input  logic    rst_i,
    input  logic    flush_i,
    btb_if.slave    bus,
    output logic    fsm_state
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic              ready_q;
    logic [IDX_W-1:0]  clr_idx;

    // Tags, targets and counters are deliberately left unreset; valid bits gate them.
    logic [NUM_WAYS-1:0] valid   [NUM_SETS];
    logic [TAG_W-1:0]    tags    [NUM_SETS][NUM_WAYS];
    logic [ADDR_W-1:0]   targets [NUM_SETS][NUM_WAYS];
    logic [1:0]          ctrs    [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    victim  [NUM_SETS];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_match;
    logic [WAY_W-1:0] lk_way;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_match;
    logic [WAY_W-1:0] up_way;
    logic             free_found;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] alloc_way;
    logic [WAY_W-1:0] next_victim;

    assign lk_idx = bus.pc[IDX_W+1:2];
    assign lk_tag = bus.pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Scanning from the top way down leaves the lowest matching way selected.
    always_comb begin
        lk_match = 1'b0;
        lk_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid[lk_idx][w] && (tags[lk_idx][w] == lk_tag)) begin
                lk_match = 1'b1;
                lk_way   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        up_match   = 1'b0;
        up_way     = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid[up_idx][w] && (tags[up_idx][w] == up_tag)) begin
                up_match = 1'b1;
                up_way   = WAY_W'(w);
            end
            if (!valid[up_idx][w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign alloc_way   = free_found ? free_way : victim[up_idx];
    assign next_victim = (NUM_WAYS == 1) ? '0 : victim[up_idx] + 1'b1;

    assign bus.hit         = (state == RUN) && lk_match;
    assign bus.pred_taken  = bus.hit && ctrs[lk_idx][lk_way][1];
    assign bus.pred_target = bus.pred_taken ? targets[lk_idx][lk_way] : bus.pc + ADDR_W'(4);
    assign bus.ready       = ready_q;
    assign fsm_state       = state;

    always_ff @(posedge clk) begin
        if (rst_i || flush_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    valid[clr_idx]  <= '0;
                    victim[clr_idx] <= '0;
                    clr_idx         <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(NUM_SETS - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.upd_valid) begin
                        if (up_match) begin
                            if (bus.upd_taken) begin
                                targets[up_idx][up_way] <= bus.upd_target;
                                if (ctrs[up_idx][up_way] != 2'b11)
                                    ctrs[up_idx][up_way] <= ctrs[up_idx][up_way] + 2'b01;
                            end else if (ctrs[up_idx][up_way] != 2'b00) begin
                                ctrs[up_idx][up_way] <= ctrs[up_idx][up_way] - 2'b01;
                            end
                        end else if (bus.upd_taken) begin
                            valid[up_idx][alloc_way]   <= 1'b1;
                            tags[up_idx][alloc_way]    <= up_tag;
                            targets[up_idx][alloc_way] <= bus.upd_target;
                            ctrs[up_idx][alloc_way]    <= 2'b10;
                            // Filling an empty way leaves the replacement order alone.
                            if (!free_found)
                                victim[up_idx] <= next_victim;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
